// File: rtl/apb_slave_mem_if.sv
// APB completer bus bundle for apb_slave_mem.
// PCLK and PRESET stay plain module ports and are not part of this bundle.
interface apb_slave_mem_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem.sv
// APB completer with a DEPTH x 32-bit memory.
// Two-state FSM (IDLE/ACCESS). The address, direction and write data are
// captured on the setup edge, and the read data is captured on that same edge.
// Optional wait states: define APB_SLAVE_WAIT_EN to insert WAIT_CYCLES
// PREADY=0 cycles per transfer. Without the macro, transfers are zero-wait.
// The whole memory clears on reset, so it is built from registers, not block RAM.
module apb_slave_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic          PCLK,
  input logic          PRESET,
  apb_slave_mem_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

`ifdef APB_SLAVE_WAIT_EN
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);
`else
  localparam logic [3:0] CNT_LOAD = 4'd0;
  // WAIT_CYCLES has no effect in the zero-wait build.
  logic [3:0] unused_wait_cycles;
  assign unused_wait_cycles = 4'(WAIT_CYCLES);
`endif

  logic [0:0]    state_reg;
  logic [3:0]    cnt_reg;
  logic          err_reg;
  logic          write_reg;
  logic [AW-1:0] index_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   prdata_reg;
  logic [31:0]   mem_reg [DEPTH];

  logic          setup;
  logic          active;
  logic          ready;
  logic          addr_err;
  logic          mem_we;
  logic [AW-1:0] index_in;
  logic [DEPTH-1:0] word_we;

  assign index_in = bus.PADDR[AW-1:0];
  assign addr_err = (bus.PADDR >= 32'(DEPTH));
  assign setup    = (state_reg == IDLE) & bus.PSEL & ~bus.PENABLE;
  assign active   = (state_reg == ACCESS) & bus.PSEL & bus.PENABLE;
  assign ready    = active & (cnt_reg == 4'd0);
  assign mem_we   = ready & write_reg & ~err_reg;

  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready & err_reg;
  assign bus.PRDATA  = prdata_reg;

  // One write-enable per word, decoded from the address latched at setup.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign word_we[gi] = mem_we & (index_reg == AW'(gi));
  end

  // Transfer FSM: capture on setup, count wait states, then complete or abort.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      err_reg    <= 1'b0;
      write_reg  <= 1'b0;
      index_reg  <= '0;
      wdata_reg  <= 32'd0;
      prdata_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (setup) begin
            state_reg  <= ACCESS;
            index_reg  <= index_in;
            write_reg  <= bus.PWRITE;
            wdata_reg  <= bus.PWDATA;
            cnt_reg    <= CNT_LOAD;
            err_reg    <= addr_err;
            prdata_reg <= addr_err ? 32'd0 : mem_reg[index_in];
          end
        end
        ACCESS: begin
          if (active) begin
            if (cnt_reg != 4'd0) begin
              cnt_reg <= cnt_reg - 4'd1;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            // The requester dropped PSEL or PENABLE, so the transfer is abandoned.
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Memory array: cleared on reset, written only on a successful write completion.
  always_ff @(posedge PCLK) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (PRESET) begin
        mem_reg[i] <= 32'd0;
      end else if (word_we[i]) begin
        mem_reg[i] <= wdata_reg;
      end
    end
  end

endmodule
